// File: rtl/opacc_pkg.sv
// Shared types and sizing helpers for the opacc command sequencer.
package opacc_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_MAC   = 2'd1,
    OP_STORE = 2'd2,
    OP_ZERO  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_STORE,
    ST_ZERO
  } state_e;

  // Beat counter width able to hold max_k.
  function automatic int kw_of(input int max_k);
    return $clog2(max_k + 1);
  endfunction

  // Columns per vector.
  function automatic int vl_of(input int vlen, input int xlen);
    return vlen / xlen;
  endfunction

  // Rows per matrix.
  function automatic int ml_of(input int mlen, input int xlen);
    return mlen / xlen;
  endfunction

  // mreg select width, never narrower than one bit.
  function automatic int mw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/opacc_seq.sv
// Command sequencer for the outer-product accumulator: accepts one
// LOAD/MAC/STORE/ZERO command at a time and paces vector beats through
// valid/ready handshakes while driving the opacc control and data pins.
module opacc_seq
  import opacc_pkg::*;
#(
  parameter int NUM_MREGS = 2,
  parameter int XLEN      = 8,
  parameter int VLEN      = 32,
  parameter int MLEN      = 32,
  parameter int MAX_K     = 255,
  localparam int KW = kw_of(MAX_K),
  localparam int VL = vl_of(VLEN, XLEN),
  localparam int ML = ml_of(MLEN, XLEN),
  localparam int MW = mw_of(NUM_MREGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [MW-1:0]      cmd_mreg,
  input  logic [KW-1:0]      cmd_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ML*XLEN-1:0] in_a,
  input  logic [VL*XLEN-1:0] in_b,
  input  logic [VL*XLEN-1:0] in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VL*XLEN-1:0] out_data,
  output logic               busy,
  output logic               done,
  output logic               opc_c_valid,
  output logic               opc_ab_valid,
  output logic [MW-1:0]      opc_ci_addr,
  output logic [MW-1:0]      opc_ab_addr,
  output logic [ML*XLEN-1:0] opc_ai,
  output logic [VL*XLEN-1:0] opc_bi,
  output logic [VL*XLEN-1:0] opc_ci,
  input  logic [VL*XLEN-1:0] opc_co
);

  localparam logic [KW-1:0] ML_LAST = KW'(ML - 1);

  state_e        state, state_next;
  logic [KW-1:0] cnt, cnt_next, len_q, last_idx;
  logic [MW-1:0] mreg_q;
  logic          done_q, done_next;
  logic          accept, beat;

  // State, beat counter, latched command fields and the done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mreg_q <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      done_q <= done_next;
      if (accept) begin
        mreg_q <= cmd_mreg;
        len_q  <= cmd_len;
      end
    end
  end

  // Next-state logic and all handshake / opacc outputs; everything is
  // forced low while reset is held so nothing reaches opacc mid-reset.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    done_next    = 1'b0;
    accept       = 1'b0;
    beat         = 1'b0;
    cmd_ready    = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    opc_c_valid  = 1'b0;
    opc_ab_valid = 1'b0;
    opc_ci_addr  = '0;
    opc_ab_addr  = '0;
    opc_ai       = '0;
    opc_bi       = '0;
    opc_ci       = '0;
    last_idx     = (state == ST_MAC) ? (len_q - KW'(1)) : ML_LAST;
    if (reset) begin
      unique case (state)
        ST_IDLE: begin
          cmd_ready = 1'b1;
          accept    = cmd_valid;
          if (cmd_valid) begin
            cnt_next = '0;
            case (op_e'(cmd_op))
              OP_LOAD:  state_next = ST_LOAD;
              OP_MAC: begin
                // A zero-length MAC finishes immediately without touching opacc.
                if (cmd_len == '0) done_next = 1'b1;
                else               state_next = ST_MAC;
              end
              OP_STORE: state_next = ST_STORE;
              default:  state_next = ST_ZERO;
            endcase
          end
        end
        ST_LOAD: begin
          in_ready = 1'b1;
          beat     = in_valid;
          if (in_valid) begin
            opc_c_valid = 1'b1;
            opc_ci      = in_c;
            opc_ci_addr = mreg_q;
          end
        end
        ST_MAC: begin
          in_ready = 1'b1;
          beat     = in_valid;
          if (in_valid) begin
            opc_ab_valid = 1'b1;
            opc_ab_addr  = mreg_q;
            opc_ai       = in_a;
            opc_bi       = in_b;
          end
        end
        ST_STORE: begin
          // The select is held for the whole state so opc_co shows the
          // target mreg's bottom row even while the consumer stalls.
          out_valid   = 1'b1;
          out_data    = opc_co;
          opc_ci_addr = mreg_q;
          beat        = out_ready;
          opc_c_valid = out_ready;
        end
        ST_ZERO: begin
          beat        = 1'b1;
          opc_c_valid = 1'b1;
          opc_ci_addr = mreg_q;
        end
        default: state_next = ST_IDLE;
      endcase
      if (beat) begin
        if (cnt == last_idx) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + KW'(1);
        end
      end
    end
  end

  assign busy = reset && (state != ST_IDLE);
  assign done = reset && done_q;

endmodule
